// File: rtl/ddr_pkg.sv
// Shared DDR request types: default geometry and the {row, bank, col, we} entry
// layout used by ddr_req_queue and address_hold_buffer.
package ddr_pkg;

  localparam int ROW_W  = 14;
  localparam int BANK_W = 3;
  localparam int COL_W  = 10;
  localparam int ADDR_W = ROW_W + BANK_W + COL_W;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
    logic [COL_W-1:0]  col;
    logic              we;
  } ddr_req_t;

endpackage

// File: rtl/ddr_req_fifo_mem.sv
// Entry storage for ddr_req_queue: synchronous write, combinational read so the
// head entry falls through without an extra cycle.
module ddr_req_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = $bits(ddr_pkg::ddr_req_t),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [PTR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ddr_req_queue.sv
// Host request queue in front of address_hold_buffer: splits row/bank/col at push
// and presents the head first-word-fall-through. DDR_REQ_QUEUE_PERF_EN adds counters.
module ddr_req_queue #(
  parameter int DEPTH  = 8,
  parameter int ROW_W  = ddr_pkg::ROW_W,
  parameter int BANK_W = ddr_pkg::BANK_W,
  parameter int COL_W  = ddr_pkg::COL_W,
  localparam int ADDR_W = ROW_W + BANK_W + COL_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_row,
  output logic [BANK_W-1:0] out_bank,
  output logic [COL_W-1:0]  out_col,
  output logic              out_we,
  output logic [CNT_W-1:0]  count
`ifdef DDR_REQ_QUEUE_PERF_EN
  ,
  output logic [15:0]       acc_cnt,
  output logic [15:0]       stall_cnt,
  output logic [CNT_W-1:0]  max_occ
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Same field order as ddr_pkg::ddr_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
    logic [COL_W-1:0]  col;
    logic              we;
  } entry_t;

  localparam int ENT_W = $bits(entry_t);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_out_valid;
  entry_t           w_wr_ent;
  entry_t           w_head;
  logic [ENT_W-1:0] w_rd_data;

  assign w_out_valid = (r_count != '0);
  assign w_push      = req_valid && r_ready;
  assign w_pop       = w_out_valid && out_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Ready looks at the post-edge count, so going full blocks the very next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_next;
      r_ready <= (w_count_next < CNT_FULL);
    end
  end

  assign w_wr_ent.row  = req_addr[ADDR_W-1 -: ROW_W];
  assign w_wr_ent.bank = req_addr[COL_W +: BANK_W];
  assign w_wr_ent.col  = req_addr[COL_W-1:0];
  assign w_wr_ent.we   = req_we;

  ddr_req_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_ent),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign w_head    = w_rd_data;
  assign out_valid = w_out_valid;
  assign out_row   = w_out_valid ? w_head.row  : '0;
  assign out_bank  = w_out_valid ? w_head.bank : '0;
  assign out_col   = w_out_valid ? w_head.col  : '0;
  assign out_we    = w_out_valid ? w_head.we   : 1'b0;
  assign req_ready = r_ready;
  assign count     = r_count;

`ifdef DDR_REQ_QUEUE_PERF_EN
  logic [15:0]      r_acc_cnt;
  logic [15:0]      r_stall_cnt;
  logic [CNT_W-1:0] r_max_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_cnt   <= '0;
      r_stall_cnt <= '0;
      r_max_occ   <= '0;
    end else begin
      if (w_push && (r_acc_cnt != 16'hFFFF)) r_acc_cnt <= r_acc_cnt + 16'd1;
      if (req_valid && !r_ready && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_count_next > r_max_occ) r_max_occ <= w_count_next;
    end
  end

  assign acc_cnt   = r_acc_cnt;
  assign stall_cnt = r_stall_cnt;
  assign max_occ   = r_max_occ;
`endif

endmodule
